output_display: RTL and testbench

OUTPUT_DISPLAY -- requirements
Module: output_display

---
 rtl/output_display_pkg.sv | 41 ++++
 rtl/output_display_bin2bcd.sv | 51 +++++
 rtl/output_display.sv | 111 +++++++++++
 tb/tb_output_display.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/output_display_pkg.sv
// Shared types and seven-segment constants for the output_display block.
// Segment bit order is {g,f,e,d,c,b,a}, active high.
package output_display_pkg;

  typedef enum logic {
    IDLE,
    CONVERT
  } state_t;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = SEG_0;
      4'd1:    seg_encode = SEG_1;
      4'd2:    seg_encode = SEG_2;
      4'd3:    seg_encode = SEG_3;
      4'd4:    seg_encode = SEG_4;
      4'd5:    seg_encode = SEG_5;
      4'd6:    seg_encode = SEG_6;
      4'd7:    seg_encode = SEG_7;
      4'd8:    seg_encode = SEG_8;
      4'd9:    seg_encode = SEG_9;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/output_display_bin2bcd.sv
// Sequential double-dabble: 8-bit binary to 3-digit BCD, one shift-add-3 step per cycle.
// done is high during the cycle whose closing edge completes the conversion and loads bcd.
module bin2bcd
  import output_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  state_t      state;
  logic [2:0]  step;
  logic [19:0] work;
  logic [19:0] work_next;
  logic [11:0] adj;

  always_comb begin
    adj = work[19:8];
    for (int unsigned i = 0; i < 3; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
    end
    work_next = {adj, work[7:0]} << 1;
  end

  assign done = (state == CONVERT) && (step == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= '0;
      work  <= '0;
      bcd   <= '0;
    end else begin
      if (done) bcd <= work_next[19:8];
      // A start on the completion edge chains straight into the next conversion.
      if (start && (state == IDLE || done)) begin
        state <= CONVERT;
        step  <= '0;
        work  <= {12'h000, bin};
      end else if (state == CONVERT) begin
        work <= work_next;
        step <= step + 3'd1;
        if (done) state <= IDLE;
      end
    end
  end

endmodule

// File: rtl/output_display.sv
// CPU output register display: BCD conversion with one-deep pending load, multiplexed 4-digit scan.
// Define DISPLAY_SIGNED_EN to treat out_data as two's complement and show a minus on digit 3.
module output_display
  import output_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1024
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  out_load,
  input  logic [7:0]            out_data,
  output logic                  busy,
  output logic                  valid,
  output logic [11:0]           bcd,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [6:0]            segments
);

  logic        done;
  logic        start;
  logic [7:0]  start_data;
  logic [7:0]  start_mag;
  logic        pend_valid;
  logic [7:0]  pend_data;
  logic [15:0] scan_cnt;
  logic [6:0]  sign_seg;

  // A load on the completion edge wins over whatever was pending.
  always_comb begin
    start      = 1'b0;
    start_data = out_data;
    if (!busy) begin
      start = out_load;
    end else if (done) begin
      start      = out_load | pend_valid;
      start_data = out_load ? out_data : pend_data;
    end
  end

`ifdef DISPLAY_SIGNED_EN
  logic conv_neg;
  logic disp_neg;

  assign start_mag = start_data[7] ? (~start_data + 8'd1) : start_data;
  assign sign_seg  = disp_neg ? SEG_MINUS : SEG_BLANK;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      conv_neg <= 1'b0;
      disp_neg <= 1'b0;
    end else begin
      if (start) conv_neg <= start_data[7];
      if (done)  disp_neg <= conv_neg;
    end
  end
`else
  assign start_mag = start_data;
  assign sign_seg  = SEG_BLANK;
`endif

  bin2bcd u_bin2bcd (
    .clk   (clk),
    .rst_n (clr),
    .start (start),
    .bin   (start_mag),
    .done  (done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      busy       <= 1'b0;
      valid      <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else begin
      busy <= start | (busy & ~done);
      if (done) valid <= 1'b1;
      if (busy && !done && out_load) begin
        pend_valid <= 1'b1;
        pend_data  <= out_data;
      end else if (done) begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      scan_cnt  <= '0;
      digit_sel <= NUM_DIGITS'(1);
    end else if (scan_cnt == 16'(SCAN_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_sel <= {digit_sel[NUM_DIGITS-2:0], digit_sel[NUM_DIGITS-1]};
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  always_comb begin
    segments = SEG_BLANK;
    case (digit_sel)
      4'b0001: segments = seg_encode(bcd[3:0]);
      4'b0010: segments = (bcd[11:4] == 8'h00) ? SEG_BLANK : seg_encode(bcd[7:4]);
      4'b0100: segments = (bcd[11:8] == 4'h0) ? SEG_BLANK : seg_encode(bcd[11:8]);
      4'b1000: segments = sign_seg;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: tb/tb_output_display.sv
// Scoreboard bench for output_display (SCAN_DIV=4); expectations follow DISPLAY_SIGNED_EN if defined.
module tb_output_display;

`ifdef DISPLAY_SIGNED_EN
  localparam logic [11:0] FF_BCD = 12'h001;
  localparam logic [27:0] FF_SEG = {7'h40, 7'h00, 7'h00, 7'h06};
  localparam logic [6:0]  NEG_SEG = 7'h40;
`else
  localparam logic [11:0] FF_BCD = 12'h255;
  localparam logic [27:0] FF_SEG = {7'h00, 7'h5B, 7'h6D, 7'h6D};
  localparam logic [6:0]  NEG_SEG = 7'h00;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        out_load = 1'b0;
  logic [7:0]  out_data = '0;
  logic        busy, valid;
  logic [11:0] bcd;
  logic [3:0]  digit_sel;
  logic [6:0]  segments;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [11:0] bcd;
    int          due;
  } exp_t;
  exp_t sb[$];

  output_display #(.SCAN_DIV(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .out_load  (out_load),
    .out_data  (out_data),
    .busy      (busy),
    .valid     (valid),
    .bcd       (bcd),
    .digit_sel (digit_sel),
    .segments  (segments)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [11:0] v, input int due);
    exp_t e;
    e.bcd = v;
    e.due = due;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] d);
    out_load = 1'b1;
    out_data = d;
    tick();
    out_load = 1'b0;
  endtask

  task automatic wait_sel(input logic [3:0] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (digit_sel == want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic scan_check(input string name, input logic [27:0] segs);
    bit ok;
    logic [3:0] want;
    for (int d = 0; d < 4; d++) begin
      want = 4'b0001 << d;
      wait_sel(want, ok);
      chk({name, "_sel_reached"}, 32'(ok), 32'd1);
      if (ok) chk($sformatf("%s_seg%0d", name, d), 32'(segments), 32'(segs[d*7 +: 7]));
    end
  endtask

  // Monitor: every change of the displayed result must match the next scoreboard entry.
  initial begin
    logic [12:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!clr) begin
        prev = '0;
      end else if ({valid, bcd} != prev) begin
        prev = {valid, bcd};
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_update: bcd=%h valid=%b with nothing expected (cycle %0d)", bcd, valid, cyc);
        end else begin
          e = sb.pop_front();
          chk("result_bcd", 32'(bcd), 32'(e.bcd));
          chk("result_cycle", cyc, e.due);
          chk("result_valid", 32'(valid), 32'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, t0;
    bit ok;
    logic [3:0] s;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'h000);
    chk("rst_sel", 32'(digit_sel), 32'h1);
    chk("rst_seg", 32'(segments), 32'h3F);

    // Release and load on the very first rising edge afterwards.
    clr = 1'b1;
    load(8'hFF); c = cyc;
    push(FF_BCD, c + 8);
    chk("ff_busy_start", 32'(busy), 32'd1);
    repeat (7) tick();
    chk("ff_busy_hold", 32'(busy), 32'd1);
    tick();
    chk("ff_busy_done", 32'(busy), 32'd0);
    chk("ff_valid", 32'(valid), 32'd1);
    scan_check("ff", FF_SEG);

    load(8'h80); c = cyc;
    push(12'h128, c + 8);
    repeat (8) tick();
    scan_check("x80", {NEG_SEG, 7'h06, 7'h5B, 7'h7F});

    load(8'h00); c = cyc;
    push(12'h000, c + 8);
    repeat (8) tick();
    scan_check("x00", {7'h00, 7'h00, 7'h00, 7'h3F});

    // Back-to-back: 0x2A is overwritten by 0x63 while 0x07 converts.
    load(8'h07); c = cyc;
    push(12'h007, c + 8);
    push(12'h099, c + 16);
    tick();
    load(8'h2A);
    tick();
    load(8'h63);
    repeat (12) tick();
    chk("b2b_busy_end", 32'(busy), 32'd0);
    scan_check("x63", {7'h00, 7'h00, 7'h6F, 7'h6F});

    load(8'h07); c = cyc;
    push(12'h007, c + 8);
    repeat (8) tick();
    scan_check("x07", {7'h00, 7'h00, 7'h00, 7'h07});

    // Load on the completion edge supersedes the pending 0x22.
    load(8'h0C); c = cyc;
    push(12'h012, c + 8);
    push(12'h100, c + 16);
    repeat (2) tick();
    load(8'h22);
    repeat (4) tick();
    load(8'h64);
    chk("sup_busy_chain", 32'(busy), 32'd1);
    repeat (8) tick();
    chk("sup_busy_end", 32'(busy), 32'd0);
    repeat (12) tick();
    scan_check("x64", {7'h00, 7'h06, 7'h3F, 7'h3F});

    // Scan period and wrap.
    s = digit_sel;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (digit_sel != s) begin ok = 1'b1; break; end
    end
    t0 = cyc;
    s = digit_sel;
    for (int i = 0; i < 10 && ok; i++) begin
      @(negedge clk);
      if (digit_sel != s) break;
    end
    chk("scan_period", cyc - t0, 4);
    wait_sel(4'b1000, ok);
    chk("scan_reach_1000", 32'(ok), 32'd1);
    repeat (4) @(negedge clk);
    chk("scan_wrap", 32'(digit_sel), 32'h1);
    chk("scan_wrap_seg", 32'(segments), 32'h3F);

    // Reset four cycles into converting 0xC8 with 0x11 pending.
    load(8'hC8); c = cyc;
    tick();
    load(8'h11);
    tick();
    chk("mid_busy_before_rst", 32'(busy), 32'd1);
    clr = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_bcd", 32'(bcd), 32'h000);
    chk("mid_rst_sel", 32'(digit_sel), 32'h1);
    chk("mid_rst_seg", 32'(segments), 32'h3F);
    repeat (3) tick();
    clr = 1'b1;
    repeat (24) tick();
    chk("post_rst_bcd", 32'(bcd), 32'h000);
    chk("post_rst_valid", 32'(valid), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
